fwd_scoreboard: RTL

//  Parametrised forwarding and interlock unit, successor to the fixed 2-source/2-stage forward unit.
//  - Tracks DEPTH in-flight writers in a shifting slot table. Slot 0 = EX; slot DEPTH-1 = last stage before register-file write.
//  - Per writer: a variable result latency.
//  - For each of NUM_SRC operands in ID, selects register file or the youngest matching slot.
//  - Raises a load-use/multicycle stall when the matching producer's result is not yet ready.

---
 rtl/fwd_scoreboard_pkg.sv | 12 +
 rtl/fwd_match_lane.sv | 42 ++++
 rtl/fwd_scoreboard.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// Shared constants and helpers for the forwarding scoreboard.
// Slot record: valid, wb, rd[REG_AW], cnt[SEL_W], held as parallel per-field vectors in the top.
package fwd_scoreboard_pkg;

  localparam int FWD_SEL_RF = 0;
  localparam int REG_ZERO   = 0;

  function automatic int calc_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fwd_match_lane.sv
// Priority lookup for one source operand over the in-flight slot table.
// The youngest matching slot (lowest index) decides between forwarding and not-ready.
module fwd_match_lane
  import fwd_scoreboard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 4,
  parameter int SEL_W  = 3
) (
  input  logic                    src_valid,
  input  logic [REG_AW-1:0]       src_addr,
  input  logic [DEPTH-1:0]        slot_valid,
  input  logic [DEPTH-1:0]        slot_wb,
  input  logic [DEPTH*REG_AW-1:0] slot_rd,
  input  logic [DEPTH*SEL_W-1:0]  slot_cnt,
  output logic [SEL_W-1:0]        sel,
  output logic                    not_ready
);

  logic lane_live;

  assign lane_live = src_valid && (src_addr != REG_AW'(REG_ZERO));

  // Scan oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    sel       = SEL_W'(FWD_SEL_RF);
    not_ready = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (lane_live && slot_valid[k] && slot_wb[k] &&
          (slot_rd[k*REG_AW +: REG_AW] == src_addr)) begin
        if (slot_cnt[k*SEL_W +: SEL_W] == '0) begin
          sel       = SEL_W'(k + 1);
          not_ready = 1'b0;
        end else begin
          sel       = SEL_W'(FWD_SEL_RF);
          not_ready = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Parametrised forwarding/interlock scoreboard: shifting slot table plus per-operand match lanes.
// Define FWD_SCOREBOARD_PERF_EN to add the stall performance counters.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 3,
  parameter int DEPTH   = 4,
  parameter int SEL_W   = calc_sel_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*REG_AW-1:0] src_addr,
  input  logic                      issue_valid,
  input  logic                      issue_wb,
  input  logic [REG_AW-1:0]         issue_rd,
  input  logic [SEL_W-1:0]          issue_lat,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
`ifdef FWD_SCOREBOARD_PERF_EN
  output logic [31:0]               perf_stall_cnt,
  output logic [7:0]                perf_max_run,
`endif
  output logic                      stall,
  output logic                      issue_fire
);

  logic [DEPTH-1:0]        slot_valid_q, slot_valid_d;
  logic [DEPTH-1:0]        slot_wb_q, slot_wb_d;
  logic [DEPTH*REG_AW-1:0] slot_rd_q, slot_rd_d;
  logic [DEPTH*SEL_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [NUM_SRC-1:0]      lane_not_ready;
  logic [SEL_W-1:0]        lat_eff;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    fwd_match_lane #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .SEL_W  (SEL_W)
    ) u_lane (
      .src_valid  (src_valid[i]),
      .src_addr   (src_addr[i*REG_AW +: REG_AW]),
      .slot_valid (slot_valid_q),
      .slot_wb    (slot_wb_q),
      .slot_rd    (slot_rd_q),
      .slot_cnt   (slot_cnt_q),
      .sel        (fwd_sel[i*SEL_W +: SEL_W]),
      .not_ready  (lane_not_ready[i])
    );
  end

  assign stall      = issue_valid && (|lane_not_ready);
  assign issue_fire = issue_valid && !stall;

  // Latency is clamped to 1..DEPTH so the countdown always expires inside the table.
  always_comb begin
    lat_eff = issue_lat;
    if (issue_lat == '0) begin
      lat_eff = SEL_W'(1);
    end else if (issue_lat > SEL_W'(DEPTH)) begin
      lat_eff = SEL_W'(DEPTH);
    end
  end

  always_comb begin
    slot_valid_d = '0;
    slot_wb_d    = '0;
    slot_rd_d    = '0;
    slot_cnt_d   = '0;
    slot_valid_d[0]          = issue_fire;
    slot_wb_d[0]             = issue_wb && (issue_rd != REG_AW'(REG_ZERO));
    slot_rd_d[0 +: REG_AW]   = issue_rd;
    slot_cnt_d[0 +: SEL_W]   = lat_eff - SEL_W'(1);
    for (int k = 1; k < DEPTH; k++) begin
      // A flushed EX instruction still shifts down, but as a bubble.
      slot_valid_d[k] = slot_valid_q[k-1] && !((k == 1) && flush);
      slot_wb_d[k]    = slot_wb_q[k-1];
      slot_rd_d[k*REG_AW +: REG_AW] = slot_rd_q[(k-1)*REG_AW +: REG_AW];
      if (slot_cnt_q[(k-1)*SEL_W +: SEL_W] != '0) begin
        slot_cnt_d[k*SEL_W +: SEL_W] = slot_cnt_q[(k-1)*SEL_W +: SEL_W] - SEL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid_q <= '0;
      slot_wb_q    <= '0;
      slot_rd_q    <= '0;
      slot_cnt_q   <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_wb_q    <= slot_wb_d;
      slot_rd_q    <= slot_rd_d;
      slot_cnt_q   <= slot_cnt_d;
    end
  end

`ifdef FWD_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]  cur_run_q, cur_run_d;
  logic [7:0]  max_run_q, max_run_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    cur_run_d   = '0;
    if (stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
      cur_run_d = (cur_run_q != '1) ? cur_run_q + 8'd1 : cur_run_q;
    end
    max_run_d = (cur_run_d > max_run_q) ? cur_run_d : max_run_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      cur_run_q   <= '0;
      max_run_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      cur_run_q   <= cur_run_d;
      max_run_q   <= max_run_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_max_run   = max_run_q;
`endif

endmodule
